regbus_arbiter: RTL and testbench
=================================

REGBUS_ARBITER -- requirements
Module: regbus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register address width.
REQ-002 SHALL have parameter DATA_W, default 8, register data width.
REQ-003 SHALL have parameter LOCK_LO, default 2, lowest address write-protected while lock is high.
REQ-004 SHALL have parameter LOCK_HI, default 5, highest address write-protected while lock is high.
REQ-005 SHALL have port clk  input  1  the single clock; all logic rises on posedge clk.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have ports req0/req1  input  1  access request from requester 0/1.
REQ-008 SHALL have ports we0/we1  input  1  1=write, 0=read; held stable while req is high.
REQ-009 SHALL have ports addr0/addr1  input  ADDR_W  target register; held stable while req is high.
REQ-010 SHALL have ports wdata0/wdata1  input  DATA_W  write data; held stable while req is high.
REQ-011 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports err0/err1  output  1  one-cycle pulse coincident with ack, meaning the write was rejected.
REQ-013 SHALL have ports rdata0/rdata1  output  DATA_W  registered read data, valid from the ack cycle until that requester's next ack.
REQ-014 SHALL have port lock  input  1  write protection for LOCK_LO..LOCK_HI (PWM running).
REQ-015 SHALL have port reg_we  output  1  shared register-file write strobe.
REQ-016 SHALL have port reg_addr  output  ADDR_W  shared register-file address.
REQ-017 SHALL have port reg_wdata  output  DATA_W  shared register-file write data.
REQ-018 SHALL have port reg_rdata  input  DATA_W  combinational read data at reg_addr.

Function
REQ-019 SHALL use an FSM with states IDLE, ACCESS, DONE, RELEASE.
REQ-020 IDLE: if any req is high, SHALL latch the winner into a grant register and move to ACCESS next cycle; otherwise stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: if both req are high, the requester not granted last wins; with a single req, that requester wins.
REQ-022 ACCESS (one cycle): reg_addr/reg_wdata SHALL carry the winner's addr/wdata; reg_we=1 only for a permitted write; for any access, reg_rdata SHALL be captured into the winner's rdata register.
REQ-023 A write SHALL be rejected when addr==0 (read-only ID), or when lock==1 during ACCESS and LOCK_LO<=addr<=LOCK_HI.
REQ-024 DONE (one cycle): the winner's ack SHALL be 1; the winner's err SHALL be 1 iff the write was rejected; then go to RELEASE.
REQ-025 RELEASE: SHALL wait until the winner's req is 0, then go to IDLE. The other requester stays pending and is not starved.
REQ-026 Latency: req high in IDLE at cycle n -> reg_we/capture at n+1 -> ack at n+2; minimum 4 cycles per grant.
REQ-027 reg_we SHALL be 0 in every state except ACCESS; ack/err of the non-winner SHALL be 0 always.
REQ-028 reg_addr and reg_wdata SHALL be 0 outside ACCESS.
REQ-029 A req that drops before ack SHALL still complete; the ack is issued and RELEASE exits immediately.
REQ-030 lock SHALL be sampled only in ACCESS; changes at other times SHALL have no effect on an access already past ACCESS.

Reset
REQ-031 While rst_n==0 at posedge clk: state=IDLE; ack0/1, err0/1 and reg_we = 0; rdata0/1, reg_addr and reg_wdata = 0; last-grant pointer = 1, so requester 0 wins the first tie.
REQ-032 Reset asserted mid-access SHALL abort it: no ack and no further reg_we; a write already strobed in ACCESS is not undone.

Verification
REQ-033 Write: req0=1, we0=1, addr0=3, wdata0=8'hA5, lock=0 -> reg_we=1, reg_addr=3, reg_wdata=A5 at n+1; ack0=1, err0=0 at n+2.
REQ-034 Read: req1=1, we1=0, addr1=7, reg_rdata=8'h3C -> ack1 at n+2 with rdata1=3C; reg_we stays 0 throughout.
REQ-035 Tie after reset: req0=req1=1 in the same cycle -> requester 0 acked first; after req0 drops, requester 1 acked; second tie -> requester 0 again.
REQ-036 Lock: lock=1, write to addr 4 -> reg_we stays 0, ack=1 with err=1; write to addr 1 -> reg_we=1, err=0; write to addr 0 with lock=0 -> err=1.
REQ-037 Reset in ACCESS: rst_n=0 at n+1 -> no ack at n+2; all outputs 0; the next req is serviced normally.
REQ-038 Held req: req0 held high after ack0 -> no second ack0 until req0 goes low and high again; a pending req1 is granted in the meantime.

Source files
------------

// File: rtl/regbus_arbiter.sv
// -----------------------------------------------------------------------------
// regbus_arbiter
//
// Two-requester arbiter in front of a single shared register file. Each grant
// runs through IDLE -> ACCESS -> DONE -> RELEASE:
//    IDLE    : pick a winner (round-robin on a tie) and latch its request.
//    ACCESS  : drive the register file and capture reg_rdata for the winner.
//    DONE    : the winner's ack is high (with err if the write was refused).
//    RELEASE : wait for the winner to drop req so that one request gives
//              exactly one ack.
//
// Ports
//    clk                  single clock, every register updates on its rising edge
//    rst_n                synchronous active-low reset
//    req0/req1            access request, one per requester
//    we0/we1              1 = write, 0 = read
//    addr0/addr1          target register address
//    wdata0/wdata1        write data
//    ack0/ack1            one-cycle completion pulse
//    err0/err1            one-cycle pulse with ack: the write was refused
//    rdata0/rdata1        read data captured during that requester's access
//    lock                 write-protect addresses LOCK_LO..LOCK_HI
//    reg_we               register-file write strobe (high only in ACCESS)
//    reg_addr             register-file address (0 outside ACCESS)
//    reg_wdata            register-file write data (0 outside ACCESS)
//    reg_rdata            combinational register-file read data at reg_addr
// -----------------------------------------------------------------------------
module regbus_arbiter #(
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 8,
   parameter int LOCK_LO = 2,
   parameter int LOCK_HI = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   input  logic              lock,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      DONE    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LOCK_LO_A = ADDR_W'(LOCK_LO);
   localparam logic [ADDR_W-1:0] LOCK_HI_A = ADDR_W'(LOCK_HI);

   state_t            r_state;
   logic              r_last;     // requester granted most recently
   logic              r_grant;    // requester owning the current grant
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_ack0;
   logic              r_ack1;
   logic              r_err0;
   logic              r_err1;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   logic              w_win;
   logic              w_access;
   logic              w_in_lock;
   logic              w_reject;
   logic              w_req_win;

   // On a tie the requester not granted last wins; otherwise whoever asks.
   // With only req1 high, ~req0 is 1; with only req0 high it is 0.
   assign w_win     = (req0 && req1) ? ~r_last : ~req0;

   assign w_access  = (r_state == ACCESS);
   assign w_in_lock = (r_addr >= LOCK_LO_A) && (r_addr <= LOCK_HI_A);

   // Address 0 is the read-only ID register. lock is looked at live during
   // the ACCESS cycle only; the verdict is frozen into err on leaving ACCESS,
   // so later lock changes cannot alter an access already past that point.
   assign w_reject  = r_we && ((r_addr == '0) || (lock && w_in_lock));

   assign w_req_win = r_grant ? req1 : req0;

   // The bus is driven from the latched request, so a requester dropping req
   // (or changing addr after dropping it) mid-access cannot disturb the cycle.
   assign reg_we    = w_access && r_we && !w_reject;
   assign reg_addr  = w_access ? r_addr  : '0;
   assign reg_wdata = w_access ? r_wdata : '0;

   assign ack0      = r_ack0;
   assign ack1      = r_ack1;
   assign err0      = r_err0;
   assign err1      = r_err1;
   assign rdata0    = r_rdata0;
   assign rdata1    = r_rdata1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;   // so requester 0 wins the first tie
         r_grant  <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_err0   <= 1'b0;
         r_err1   <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         // ack/err are single-cycle pulses: raised only on ACCESS -> DONE.
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err0 <= 1'b0;
         r_err1 <= 1'b0;

         case (r_state)
            IDLE: begin
               if (req0 || req1) begin
                  r_grant <= w_win;
                  r_last  <= w_win;
                  r_we    <= w_win ? we1    : we0;
                  r_addr  <= w_win ? addr1  : addr0;
                  r_wdata <= w_win ? wdata1 : wdata0;
                  r_state <= ACCESS;
               end
            end

            ACCESS: begin
               // Read data is captured for writes as well as reads.
               if (r_grant) begin
                  r_rdata1 <= reg_rdata;
                  r_ack1   <= 1'b1;
                  r_err1   <= w_reject;
               end else begin
                  r_rdata0 <= reg_rdata;
                  r_ack0   <= 1'b1;
                  r_err0   <= w_reject;
               end
               r_state <= DONE;
            end

            DONE: begin
               r_state <= RELEASE;
            end

            RELEASE: begin
               // A requester holding req after its ack is not re-granted until
               // it drops req; the other side is then served by round-robin.
               if (!w_req_win) begin
                  r_state <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regbus_arbiter
//
// Directed bench for regbus_arbiter with default parameters. Inputs change
// 1 time unit after a rising edge; outputs are checked in the same window.
// One line per transaction, one summary line at the end.
// -----------------------------------------------------------------------------
module tb_regbus_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [2:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       ack0, ack1, err0, err1;
   logic [7:0] rdata0, rdata1;
   logic       lock;
   logic       reg_we;
   logic [2:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   regbus_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack0      (ack0),
      .ack1      (ack1),
      .err0      (err0),
      .err1      (err1),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .lock      (lock),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // Directed write. lock is held at the opposite value in IDLE and DONE and
   // at lk only during the ACCESS cycle, so only the ACCESS sample may matter.
   task automatic wr(input string tag, input bit who, input logic [2:0] a,
                     input logic [7:0] d, input bit lk,
                     input bit exp_we, input bit exp_err);
      lock = ~lk;
      if (who) begin req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d; end
      else     begin req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d; end
      tick();                          // now in ACCESS
      lock = lk;
      #1;
      chk({tag, ".reg_we"},   {31'd0, reg_we}, {31'd0, exp_we});
      chk({tag, ".reg_addr"}, {29'd0, reg_addr}, {29'd0, a});
      tick();                          // now in DONE
      lock = ~lk;
      #1;
      chk({tag, ".reg_we_done"}, {31'd0, reg_we}, 32'd0);
      chk({tag, ".ack"}, {30'd0, ack1, ack0}, who ? 32'd2 : 32'd1);
      chk({tag, ".err"}, {30'd0, err1, err0},
          exp_err ? (who ? 32'd2 : 32'd1) : 32'd0);
      $display("wr   %s who=%0d addr=%0d lock=%0b -> ack=%b%b err=%b%b",
               tag, who, a, lk, ack1, ack0, err1, err0);
      req0 = 1'b0; req1 = 1'b0;
      tick();                          // RELEASE
      tick();                          // IDLE
      lock = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; lock = 1'b0;
      reg_rdata = '0;

      // ---- reset state ----
      tick(); tick();
      chk("rst.ack",   {30'd0, ack1, ack0}, 32'd0);
      chk("rst.err",   {30'd0, err1, err0}, 32'd0);
      chk("rst.bus",   {20'd0, reg_we, reg_addr, reg_wdata}, 32'd0);
      chk("rst.rdata", {16'd0, rdata1, rdata0}, 32'd0);
      $display("rst  ack=%b%b reg_we=%b", ack1, ack0, reg_we);
      rst_n = 1'b1;
      tick();

      // ---- simple write from requester 0 ----
      req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 8'hA5;
      tick();
      chk("w.reg_we",    {31'd0, reg_we}, 32'd1);
      chk("w.reg_addr",  {29'd0, reg_addr}, 32'd3);
      chk("w.reg_wdata", {24'd0, reg_wdata}, 32'hA5);
      chk("w.early_ack", {30'd0, ack1, ack0}, 32'd0);
      tick();
      chk("w.ack",       {30'd0, ack1, ack0}, 32'd1);
      chk("w.err",       {30'd0, err1, err0}, 32'd0);
      chk("w.idle_bus",  {20'd0, reg_we, reg_addr, reg_wdata}, 32'd0);
      $display("wr   addr=3 data=A5 -> ack0=%b err0=%b", ack0, err0);
      req0 = 1'b0;
      tick();
      chk("w.ack_pulse", {30'd0, ack1, ack0}, 32'd0);
      tick();

      // ---- read from requester 1 ----
      req1 = 1'b1; we1 = 1'b0; addr1 = 3'd7; reg_rdata = 8'h3C;
      tick();
      chk("r.reg_we",   {31'd0, reg_we}, 32'd0);
      chk("r.reg_addr", {29'd0, reg_addr}, 32'd7);
      tick();
      chk("r.ack",      {30'd0, ack1, ack0}, 32'd2);
      chk("r.rdata1",   {24'd0, rdata1}, 32'h3C);
      chk("r.reg_we2",  {31'd0, reg_we}, 32'd0);
      $display("rd   addr=7 -> ack1=%b rdata1=%h", ack1, rdata1);
      req1 = 1'b0; reg_rdata = 8'h00;
      tick(); tick();
      chk("r.rdata1_hold", {24'd0, rdata1}, 32'h3C);

      // ---- tie after reset: 0, then 1, then 0 again ----
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      addr0 = 3'd1; addr1 = 3'd2; reg_rdata = 8'h11;
      tick();
      chk("tie1.reg_addr", {29'd0, reg_addr}, 32'd1);
      tick();
      chk("tie1.ack",      {30'd0, ack1, ack0}, 32'd1);
      chk("tie1.rdata0",   {24'd0, rdata0}, 32'h11);
      $display("tie1 -> ack=%b%b", ack1, ack0);
      req0 = 1'b0; reg_rdata = 8'h22;
      tick(); tick(); tick();          // RELEASE, IDLE, ACCESS for req1
      chk("tie2.reg_addr", {29'd0, reg_addr}, 32'd2);
      tick();
      chk("tie2.ack",      {30'd0, ack1, ack0}, 32'd2);
      chk("tie2.rdata",    {16'd0, rdata1, rdata0}, 32'h2211);
      $display("tie2 -> ack=%b%b", ack1, ack0);
      req1 = 1'b0;
      tick(); tick();
      req0 = 1'b1; req1 = 1'b1;
      tick();
      chk("tie3.reg_addr", {29'd0, reg_addr}, 32'd1);
      tick();
      chk("tie3.ack",      {30'd0, ack1, ack0}, 32'd1);
      $display("tie3 -> ack=%b%b", ack1, ack0);
      req0 = 1'b0; req1 = 1'b0;
      tick(); tick();

      // ---- write protection ----
      wr("lock4",  1'b0, 3'd4, 8'h5A, 1'b1, 1'b0, 1'b1);
      wr("lock1",  1'b0, 3'd1, 8'h5A, 1'b1, 1'b1, 1'b0);
      wr("id0",    1'b0, 3'd0, 8'h77, 1'b0, 1'b0, 1'b1);
      wr("lock2",  1'b1, 3'd2, 8'h01, 1'b1, 1'b0, 1'b1);
      wr("lock5",  1'b1, 3'd5, 8'h02, 1'b1, 1'b0, 1'b1);
      wr("lock6",  1'b1, 3'd6, 8'h03, 1'b1, 1'b1, 1'b0);
      wr("unlk4",  1'b0, 3'd4, 8'h04, 1'b0, 1'b1, 1'b0);

      // ---- req dropped before ack still completes, RELEASE exits at once ----
      req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2; reg_rdata = 8'h99;
      tick();
      req0 = 1'b0;
      tick();
      chk("drop.ack",    {30'd0, ack1, ack0}, 32'd1);
      chk("drop.rdata0", {24'd0, rdata0}, 32'h99);
      $display("drop -> ack0=%b rdata0=%h", ack0, rdata0);
      tick(); tick();                  // RELEASE, IDLE
      req1 = 1'b1; we1 = 1'b0; addr1 = 3'd5;
      tick();
      chk("drop.next_addr", {29'd0, reg_addr}, 32'd5);
      tick();
      chk("drop.next_ack",  {30'd0, ack1, ack0}, 32'd2);
      req1 = 1'b0;
      tick(); tick();

      // ---- reset during ACCESS aborts the access ----
      req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; wdata0 = 8'hC3;
      tick();
      chk("rsta.reg_we", {31'd0, reg_we}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rsta.ack",  {30'd0, ack1, ack0, err1, err0} , 32'd0);
      chk("rsta.bus",  {20'd0, reg_we, reg_addr, reg_wdata}, 32'd0);
      chk("rsta.rdata", {16'd0, rdata1, rdata0}, 32'd0);
      $display("rsta -> ack=%b%b reg_we=%b", ack1, ack0, reg_we);
      rst_n = 1'b1; req0 = 1'b0;
      tick();
      req1 = 1'b1; we1 = 1'b0; addr1 = 3'd6; reg_rdata = 8'h77;
      tick();
      chk("rsta.next_addr", {29'd0, reg_addr}, 32'd6);
      tick();
      chk("rsta.next_ack",  {30'd0, ack1, ack0}, 32'd2);
      chk("rsta.next_rd",   {24'd0, rdata1}, 32'h77);
      req1 = 1'b0;
      tick(); tick();

      // ---- held req0: no second ack until it toggles; req1 served first ----
      req0 = 1'b1; we0 = 1'b0; addr0 = 3'd3; reg_rdata = 8'h44;
      tick(); tick();
      chk("hold.ack0", {30'd0, ack1, ack0}, 32'd1);
      req1 = 1'b1; we1 = 1'b0; addr1 = 3'd6;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold.stuck", {29'd0, ack1, ack0, reg_we}, 32'd0);
      end
      req0 = 1'b0;
      tick();                          // RELEASE -> IDLE
      req0 = 1'b1;
      tick();
      chk("hold.grant1_addr", {29'd0, reg_addr}, 32'd6);
      tick();
      chk("hold.ack1", {30'd0, ack1, ack0}, 32'd2);
      $display("hold -> ack=%b%b", ack1, ack0);
      req1 = 1'b0;
      tick(); tick(); tick();          // RELEASE, IDLE, ACCESS for req0
      chk("hold.grant0_addr", {29'd0, reg_addr}, 32'd3);
      tick();
      chk("hold.ack0_again", {30'd0, ack1, ack0}, 32'd1);
      $display("hold -> ack=%b%b", ack1, ack0);
      req0 = 1'b0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
